// File: rtl/vn_word_collector_if.sv
// Bit-in / word-out handshake bundle for vn_word_collector.
// Producer side: the bit strobe (data_in qualified by syn_in). Consumer side: entropy_data/entropy_valid, acked by entropy_ack.
interface vn_word_collector_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  data_in;
    logic                  syn_in;
    logic [WORD_WIDTH-1:0] entropy_data;
    logic                  entropy_valid;
    logic                  entropy_ack;

    // Valid/ack contract:
    // - entropy_valid rises when a word loads into entropy_data.
    // - entropy_data holds steady until the cycle in which entropy_valid && entropy_ack.
    // - An ack seen while entropy_valid is low is ignored.
    modport master (
        input  data_in,
        input  syn_in,
        input  entropy_ack,
        output entropy_data,
        output entropy_valid
    );

    modport slave (
        output data_in,
        output syn_in,
        output entropy_ack,
        input  entropy_data,
        input  entropy_valid
    );
endinterface

// File: rtl/vn_word_collector.sv
// Packs decorrelated bits MSB-first into words, offers them over valid/ack,
// runs a repetition-count health test and counts bits dropped while full.
module vn_word_collector #(
    parameter int WORD_WIDTH = 32,
    parameter int RUN_LIMIT  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    vn_word_collector_if.master  bus,
    output logic                 run_error,
    output logic [31:0]          discard_ctr,
    output logic                 state_dbg_o
);
    localparam int CW = $clog2(WORD_WIDTH + 1);
    localparam int RW = $clog2(RUN_LIMIT + 1);

    typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         bit_ctr_q, bit_ctr_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [31:0]           disc_q, disc_d;
    logic                  last_q, last_d;
    logic [RW-1:0]         run_q, run_d;

    logic                  bit_seen;
    logic                  accept;
    logic                  slot_free;
    logic [RW-1:0]         run_next;
    logic                  load;
    logic [WORD_WIDTH-1:0] load_word;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_ctr_d = bit_ctr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        err_d     = err_q;
        disc_d    = disc_q;
        last_d    = last_q;
        run_d     = run_q;
        load      = 1'b0;
        load_word = shift_q;

        bit_seen  = enable && bus.syn_in;
        accept    = bit_seen && !err_q;
        slot_free = !valid_q || bus.entropy_ack;

        // run_q == 0 marks the first bit after reset or an enable drop
        if (run_q == '0 || bus.data_in != last_q) begin
            run_next = RW'(1);
        end else if (run_q == RW'(RUN_LIMIT)) begin
            run_next = run_q;
        end else begin
            run_next = run_q + RW'(1);
        end

        if (!enable) begin
            shift_d   = '0;
            bit_ctr_d = '0;
            run_d     = '0;
            state_d   = COLLECT;
        end else begin
            if (bit_seen) begin
                run_d  = run_next;
                last_d = bus.data_in;
            end
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        shift_d = {shift_q[WORD_WIDTH-2:0], bus.data_in};
                        if (bit_ctr_q == CW'(WORD_WIDTH - 1)) begin
                            if (slot_free) begin
                                load      = 1'b1;
                                load_word = shift_d;
                                bit_ctr_d = '0;
                            end else begin
                                bit_ctr_d = CW'(WORD_WIDTH);
                                state_d   = FULL;
                            end
                        end else begin
                            bit_ctr_d = bit_ctr_q + CW'(1);
                        end
                    end
                end
                FULL: begin
                    if (accept && disc_q != 32'hFFFF_FFFF) begin
                        disc_d = disc_q + 32'd1;
                    end
                    if (valid_q && bus.entropy_ack) begin
                        load      = 1'b1;
                        load_word = shift_q;
                        shift_d   = '0;
                        bit_ctr_d = '0;
                        state_d   = COLLECT;
                    end
                end
                default: state_d = COLLECT;
            endcase
            // Health failure throws away whatever word is being built or held
            if (bit_seen && !err_q && run_next == RW'(RUN_LIMIT)) begin
                err_d     = 1'b1;
                shift_d   = '0;
                bit_ctr_d = '0;
                state_d   = COLLECT;
            end
        end

        if (load) begin
            data_d  = load_word;
            valid_d = 1'b1;
        end else if (valid_q && bus.entropy_ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= COLLECT;
            shift_q   <= '0;
            bit_ctr_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            disc_q    <= '0;
            last_q    <= 1'b0;
            run_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_ctr_q <= bit_ctr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            disc_q    <= disc_d;
            last_q    <= last_d;
            run_q     <= run_d;
        end
    end

    assign bus.entropy_data  = data_q;
    assign bus.entropy_valid = valid_q;
    assign run_error         = err_q;
    assign discard_ctr       = disc_q;
    assign state_dbg_o       = state_q;
endmodule

// File: tb/tb_vn_word_collector.sv
// Directed bench for vn_word_collector: expected words queued at stimulus time,
// popped and compared by a monitor on every valid/ack transfer.
module tb_vn_word_collector;
    localparam int W  = 32;
    localparam int RL = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        run_error;
    logic [31:0] discard_ctr;
    logic        state_dbg;

    vn_word_collector_if #(.WORD_WIDTH(W)) bus ();

    vn_word_collector #(.WORD_WIDTH(W), .RUN_LIMIT(RL)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .bus         (bus),
        .run_error   (run_error),
        .discard_ctr (discard_ctr),
        .state_dbg_o (state_dbg)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every valid/ack transfer must match the oldest expected word
    always @(negedge clk) begin
        if (!reset && bus.entropy_valid && bus.entropy_ack) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_word: got 0x%08h expected none", bus.entropy_data);
            end else begin
                chk("word", bus.entropy_data, exp_q.pop_front());
            end
        end
    end

    // Sends bits[n-1:0] MSB first, one strobe per cycle; optionally acks on the last bit.
    task automatic send_bits(input logic [127:0] bits, input int n, input logic ack_last);
        for (int i = n - 1; i >= 0; i--) begin
            @(posedge clk); #1;
            bus.syn_in  = 1'b1;
            bus.data_in = bits[i];
            if (i == 0 && ack_last) bus.entropy_ack = 1'b1;
        end
        @(posedge clk); #1;
        bus.syn_in = 1'b0;
        if (ack_last) bus.entropy_ack = 1'b0;
    endtask

    task automatic drop_enable();
        @(posedge clk); #1;
        enable = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
    endtask

    task automatic pulse_ack();
        @(posedge clk); #1;
        bus.entropy_ack = 1'b1;
        @(posedge clk); #1;
        bus.entropy_ack = 1'b0;
    endtask

    initial begin
        int vcnt;
        logic [127:0] pat;
        bus.data_in     = 1'b0;
        bus.syn_in      = 1'b0;
        bus.entropy_ack = 1'b0;

        // 1. Reset with toggling inputs
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            enable          = 1'($urandom_range(0, 1));
            bus.syn_in      = 1'($urandom_range(0, 1));
            bus.data_in     = 1'($urandom_range(0, 1));
            bus.entropy_ack = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("rst_valid", 32'(bus.entropy_valid), 32'd0);
        chk("rst_data", bus.entropy_data, 32'd0);
        chk("rst_err", 32'(run_error), 32'd0);
        chk("rst_disc", discard_ctr, 32'd0);
        @(posedge clk); #1;
        enable = 1'b0; bus.syn_in = 1'b0; bus.data_in = 1'b0; bus.entropy_ack = 1'b0;
        reset = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.entropy_valid) vcnt++;
        end
        chk("idle_valid_cycles", 32'(vcnt), 32'd0);

        // 2. Single word with ack tied high
        enable = 1'b1;
        bus.entropy_ack = 1'b1;
        exp_q.push_back(32'hAAAA_AAAA);
        send_bits(128'hAAAA_AAAA, 32, 1'b0);
        @(negedge clk);
        chk("single_valid_hi", 32'(bus.entropy_valid), 32'd1);
        @(negedge clk);
        chk("single_valid_lo", 32'(bus.entropy_valid), 32'd0);
        bus.entropy_ack = 1'b0;

        // 3. Back-pressure: two words, five discards
        drop_enable();
        exp_q.push_back(32'hCCCC_CCCC);
        exp_q.push_back(32'hCCCC_CCCC);
        pat = {59'd0, 64'hCCCC_CCCC_CCCC_CCCC, 5'b11001};
        send_bits(pat, 69, 1'b0);
        @(negedge clk);
        chk("bp_valid", 32'(bus.entropy_valid), 32'd1);
        chk("bp_held_data", bus.entropy_data, 32'hCCCC_CCCC);
        chk("bp_discard", discard_ctr, 32'd5);
        chk("bp_state_full", 32'(state_dbg), 32'd1);
        pulse_ack();
        @(negedge clk);
        chk("bp_release_valid", 32'(bus.entropy_valid), 32'd1);
        chk("bp_release_state", 32'(state_dbg), 32'd0);
        pulse_ack();
        @(negedge clk);
        chk("bp_drain_valid", 32'(bus.entropy_valid), 32'd0);

        // 4. Ack coincides with completion of the next word
        drop_enable();
        exp_q.push_back(32'h5A5A_5A5A);
        exp_q.push_back(32'h3C3C_3C3C);
        send_bits(128'h5A5A_5A5A, 32, 1'b0);
        send_bits(128'h3C3C_3C3C, 32, 1'b1);
        @(negedge clk);
        chk("coinc_valid", 32'(bus.entropy_valid), 32'd1);
        chk("coinc_data", bus.entropy_data, 32'h3C3C_3C3C);
        chk("coinc_discard", discard_ctr, 32'd5);
        pulse_ack();
        @(negedge clk);
        chk("coinc_drain", 32'(bus.entropy_valid), 32'd0);

        // 6. Enable drop mid-word loses the partial bits
        drop_enable();
        bus.entropy_ack = 1'b1;
        send_bits(128'b10_1100_1110, 10, 1'b0);
        drop_enable();
        exp_q.push_back(32'h1234_5678);
        send_bits(128'h1234_5678, 32, 1'b0);
        @(negedge clk);
        chk("endrop_valid", 32'(bus.entropy_valid), 32'd1);
        @(negedge clk);

        // 5. Repetition error with RUN_LIMIT = 8
        drop_enable();
        send_bits(128'b010_1111111, 10, 1'b0);
        @(negedge clk);
        chk("run_7_no_err", 32'(run_error), 32'd0);
        send_bits(128'b1, 1, 1'b0);
        @(negedge clk);
        chk("run_8_err", 32'(run_error), 32'd1);
        send_bits({64'd0, 32'hDEAD_BEEF, 32'h0000_00F1} >> 24, 40, 1'b0);
        @(negedge clk);
        chk("err_discard_same", discard_ctr, 32'd5);
        chk("err_no_word", 32'(bus.entropy_valid), 32'd0);
        chk("err_sticky", 32'(run_error), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("reset_err", 32'(run_error), 32'd0);
        chk("reset_disc", discard_ctr, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.entropy_ack = 1'b0;

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
